vga_sync_receiver: RTL and testbench
====================================

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 The block SHALL have a `clk` input, 1 bit wide: the single pixel clock. All logic SHALL be in this domain.
REQ-002 The block SHALL have a `reset` input, 1 bit wide: asynchronous, active-high reset.
REQ-003 The block SHALL have a `vga_HS` input, 1 bit wide: horizontal sync, active-low pulse.
REQ-004 The block SHALL have a `vga_VS` input, 1 bit wide: vertical sync, active-low pulse.
REQ-005 The block SHALL have a `display` input, 1 bit wide: active-video qualifier, high during visible pixels.
REQ-006 The block SHALL have an `rx_X` output, 10 bits wide: recovered column, 0-based within the active region.
REQ-007 The block SHALL have an `rx_Y` output, 10 bits wide: recovered row, 0-based within the active region.
REQ-008 The block SHALL have a `pixel_valid` output, 1 bit wide: high when `rx_X`/`rx_Y` describe a visible pixel.
REQ-009 The block SHALL have an `h_total` output, 10 bits wide: last measured line length in clocks.
REQ-010 The block SHALL have a `v_total` output, 10 bits wide: last measured frame length in lines.
REQ-011 The block SHALL have a `line_start` output, 1 bit wide: one-cycle pulse on each detected HS falling edge.
REQ-012 The block SHALL have a `frame_start` output, 1 bit wide: one-cycle pulse on each detected VS falling edge.
REQ-013 The block SHALL have a `locked` output, 1 bit wide: high while timing is stable.
REQ-014 The block SHALL have a `timing_error` output, 1 bit wide: one-cycle pulse on loss of lock.

Function
REQ-015 Inputs SHALL be registered once (stage s1). Falling edges SHALL be detected from s1 against its previous value.
REQ-016 Latency SHALL be 2 clocks from an input pin change to the corresponding output change (edge pulses, `pixel_valid`, `rx_X`).
REQ-017 `h_cnt` (10 bits) SHALL count clocks since the last HS falling edge and SHALL saturate at 1023, never wrapping.
REQ-018 On an HS falling edge: `h_total` SHALL load `h_cnt`+1, `h_cnt` SHALL clear to 0, `line_start` SHALL pulse, and `v_cnt` SHALL increment (saturating at 1023).
REQ-019 On a VS falling edge: `v_total` SHALL load `v_cnt`, `v_cnt` SHALL clear to 0, and `frame_start` SHALL pulse.
REQ-020 If the HS and VS edges coincide, the HS rules SHALL apply first; the VS rules SHALL then override the `v_cnt` update.
REQ-021 Active X SHALL clear on each HS falling edge and SHALL increment on every cycle where `display` (s1) is high; `rx_X` SHALL present its pre-increment value.
REQ-022 Active Y SHALL clear on a VS falling edge and SHALL increment once per line on the first cycle after `display` (s1) falls; `rx_Y` SHALL present the current value.
REQ-023 `pixel_valid` SHALL equal the registered s1 `display`. When `pixel_valid`=0, `rx_X` and `rx_Y` SHALL be driven to 0.
REQ-024 Lock FSM states: SEARCH, VERIFY, LOCKED.
- SEARCH -> VERIFY on a VS edge; the block captures reference values `ref_h` = `h_total` and `ref_v` = `v_total`.
- VERIFY -> LOCKED on the next VS edge if every line in the frame and the frame itself matched `ref_h`/`ref_v` exactly.
- VERIFY on mismatch: stay in VERIFY and recapture the references.
- LOCKED -> SEARCH on any line whose length ≠ `ref_h`, any frame whose length ≠ `ref_v`, or `h_cnt` reaching 1023. This transition SHALL pulse `timing_error` for one cycle.
REQ-025 `locked` SHALL be 1 only in LOCKED.
REQ-026 During VERIFY, `h_cnt` saturation SHALL force SEARCH without pulsing `timing_error`.
REQ-027 The first frame after reset SHALL never be marked locked.

Reset
REQ-028 While `reset`=1, all registers SHALL be cleared asynchronously: counters to 0, `h_total`=0, `v_total`=0, FSM=SEARCH, and every output 0.
REQ-029 Deassertion of `reset` SHALL take effect at the next `clk` edge. Reset mid-frame SHALL discard any partial measurement.

Structure
REQ-030 Shared package `vga_rx_pkg` SHALL hold:
- the FSM state enum;
- the counter width (10) and saturation value (1023);
- nominal constants H_TOTAL=800, V_TOTAL=525, H_ACTIVE=640, V_ACTIVE=480.
REQ-031 One sub-module, `vga_edge_detect`, SHALL perform the s1 register plus falling-edge pulse generation. It SHALL be instantiated for HS and for VS; `display` uses a plain s1 register.

Verification
REQ-032 Drive standard 800x525 timing (HS low 96 clocks, VS low 2 lines, `display` 640x480) -> after the second `frame_start`, `locked`=1, `h_total`=800 and `v_total`=525.
REQ-033 Locked stream -> `rx_X` SHALL run 0..639 with `pixel_valid`=1, and `rx_Y` SHALL run 0..479 across the frame, appearing 2 clocks after `display`.
REQ-034 While locked, stretch one line to 801 clocks -> `timing_error` pulses once, `locked`=0, and the block relocks after 2 clean frames.
REQ-035 While locked, hold `vga_HS` high -> `h_cnt` saturates 1023 clocks after the last edge, `timing_error` pulses, and `locked`=0.
REQ-036 Assert `reset` mid-line (for example at line 200, clock 300) -> all outputs go 0 immediately, and the first full frame after release gives no lock.
REQ-037 Place HS and VS falling edges on the same clock -> `line_start` and `frame_start` pulse together, and `v_cnt` restarts at 0.

Source files
------------

// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: shared types and constants for the VGA sync receiver.
// Counter width/saturation, nominal 640x480 timing and lock states.
package vga_rx_pkg;

    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = 10'd1023;

    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } lock_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// vga_edge_detect: registers one sync input and flags its falling
// edge. Reset clears both stages, so a line held low gives no edge.
module vga_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic fall
);

    logic s1_d, s1_q;
    logic prev_d, prev_q;

    // next-state for the input register and its one-cycle history
    always_comb begin
        s1_d   = din;
        prev_d = s1_q;
    end

    // input stage and history register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            prev_q <= prev_d;
        end
    end

    assign fall = prev_q & ~s1_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers pixel coordinates and line/frame
// lengths from a VGA sync stream and tracks timing lock.
module vga_sync_receiver (
    input  logic       clk,
    input  logic       reset,
    input  logic       vga_HS,
    input  logic       vga_VS,
    input  logic       display,
    output logic [9:0] rx_X,
    output logic [9:0] rx_Y,
    output logic       pixel_valid,
    output logic [9:0] h_total,
    output logic [9:0] v_total,
    output logic       line_start,
    output logic       frame_start,
    output logic       locked,
    output logic       timing_error
);

    import vga_rx_pkg::*;

    logic hs_fall, vs_fall;

    vga_edge_detect u_hs (
        .clk   (clk),
        .reset (reset),
        .din   (vga_HS),
        .fall  (hs_fall)
    );

    vga_edge_detect u_vs (
        .clk   (clk),
        .reset (reset),
        .din   (vga_VS),
        .fall  (vs_fall)
    );

    logic [CNT_W-1:0] h_cnt_d, h_cnt_q;
    logic [CNT_W-1:0] v_cnt_d, v_cnt_q;
    logic [CNT_W-1:0] h_total_d, h_total_q;
    logic [CNT_W-1:0] v_total_d, v_total_q;
    logic [CNT_W-1:0] x_cnt_d, x_cnt_q;
    logic [CNT_W-1:0] y_cnt_d, y_cnt_q;
    logic [CNT_W-1:0] rx_x_d, rx_x_q;
    logic [CNT_W-1:0] rx_y_d, rx_y_q;
    logic [CNT_W-1:0] ref_h_d, ref_h_q;
    logic [CNT_W-1:0] ref_v_d, ref_v_q;
    logic [CNT_W-1:0] h_len, v_len;
    logic de_s1_d, de_s1_q;
    logic de_prev_d, de_prev_q;
    logic pv_d, pv_q;
    logic ls_d, ls_q;
    logic fs_d, fs_q;
    logic err_d, err_q;
    logic bad_d, bad_q;
    logic h_bad, v_bad, h_sat;
    lock_state_e state_d, state_q;

    // counters and measurements; on a coincident HS/VS edge the
    // frame length includes the line that just started
    always_comb begin
        de_s1_d   = display;
        de_prev_d = de_s1_q;
        h_len     = sat_inc(h_cnt_q);
        v_len     = hs_fall ? sat_inc(v_cnt_q) : v_cnt_q;
        h_cnt_d   = hs_fall ? '0 : sat_inc(h_cnt_q);
        h_total_d = hs_fall ? h_len : h_total_q;
        v_cnt_d   = vs_fall ? '0 : v_len;
        v_total_d = vs_fall ? v_len : v_total_q;
        x_cnt_d   = x_cnt_q;
        if (hs_fall)
            x_cnt_d = '0;
        else if (de_s1_q)
            x_cnt_d = sat_inc(x_cnt_q);
        y_cnt_d = y_cnt_q;
        if (vs_fall)
            y_cnt_d = '0;
        else if (de_prev_q && !de_s1_q)
            y_cnt_d = sat_inc(y_cnt_q);
        rx_x_d = de_s1_q ? x_cnt_q : '0;
        rx_y_d = de_s1_q ? y_cnt_q : '0;
        pv_d   = de_s1_q;
        ls_d   = hs_fall;
        fs_d   = vs_fall;
    end

    // lock tracking: references are the lengths loaded at a VS edge
    always_comb begin
        state_d = state_q;
        ref_h_d = ref_h_q;
        ref_v_d = ref_v_q;
        bad_d   = bad_q;
        err_d   = 1'b0;
        h_bad   = hs_fall && (h_len != ref_h_q);
        v_bad   = vs_fall && (v_len != ref_v_q);
        h_sat   = (h_cnt_q == CNT_MAX);
        unique case (state_q)
            SEARCH: begin
                if (vs_fall) begin
                    state_d = VERIFY;
                    ref_h_d = h_total_d;
                    ref_v_d = v_total_d;
                    bad_d   = 1'b0;
                end
            end
            VERIFY: begin
                if (h_sat) begin
                    state_d = SEARCH;
                end else begin
                    if (h_bad)
                        bad_d = 1'b1;
                    if (vs_fall) begin
                        if (bad_q || h_bad || v_bad) begin
                            ref_h_d = h_total_d;
                            ref_v_d = v_total_d;
                            bad_d   = 1'b0;
                        end else begin
                            state_d = LOCKED;
                        end
                    end
                end
            end
            LOCKED: begin
                if (h_bad || v_bad || h_sat) begin
                    state_d = SEARCH;
                    err_d   = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // all state registers, cleared together on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            h_total_q <= '0;
            v_total_q <= '0;
            x_cnt_q   <= '0;
            y_cnt_q   <= '0;
            rx_x_q    <= '0;
            rx_y_q    <= '0;
            ref_h_q   <= '0;
            ref_v_q   <= '0;
            de_s1_q   <= 1'b0;
            de_prev_q <= 1'b0;
            pv_q      <= 1'b0;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
            err_q     <= 1'b0;
            bad_q     <= 1'b0;
            state_q   <= SEARCH;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            h_total_q <= h_total_d;
            v_total_q <= v_total_d;
            x_cnt_q   <= x_cnt_d;
            y_cnt_q   <= y_cnt_d;
            rx_x_q    <= rx_x_d;
            rx_y_q    <= rx_y_d;
            ref_h_q   <= ref_h_d;
            ref_v_q   <= ref_v_d;
            de_s1_q   <= de_s1_d;
            de_prev_q <= de_prev_d;
            pv_q      <= pv_d;
            ls_q      <= ls_d;
            fs_q      <= fs_d;
            err_q     <= err_d;
            bad_q     <= bad_d;
            state_q   <= state_d;
        end
    end

    assign rx_X         = rx_x_q;
    assign rx_Y         = rx_y_q;
    assign pixel_valid  = pv_q;
    assign h_total      = h_total_q;
    assign v_total      = v_total_q;
    assign line_start   = ls_q;
    assign frame_start  = fs_q;
    assign locked       = (state_q == LOCKED);
    assign timing_error = err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: directed bench using 800-clock lines and a
// short 8-line frame (VS low 2 lines, 640x5 visible) to keep runs short.
module tb_vga_sync_receiver;

    localparam int H    = 800;
    localparam int HS_W = 96;
    localparam int X0   = 144;
    localparam int XA   = 640;
    localparam int V    = 8;
    localparam int VS_L = 2;
    localparam int Y0   = 2;
    localparam int YA   = 5;

    logic       clk;
    logic       reset;
    logic       vga_HS;
    logic       vga_VS;
    logic       display;
    logic [9:0] rx_X;
    logic [9:0] rx_Y;
    logic       pixel_valid;
    logic [9:0] h_total;
    logic [9:0] v_total;
    logic       line_start;
    logic       frame_start;
    logic       locked;
    logic       timing_error;

    vga_sync_receiver dut (
        .clk          (clk),
        .reset        (reset),
        .vga_HS       (vga_HS),
        .vga_VS       (vga_VS),
        .display      (display),
        .rx_X         (rx_X),
        .rx_Y         (rx_Y),
        .pixel_valid  (pixel_valid),
        .h_total      (h_total),
        .v_total      (v_total),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .locked       (locked),
        .timing_error (timing_error)
    );

    int n_chk = 0;
    int n_fail = 0;

    int exp_de = 0, exp_x = 0, exp_y = 0, exp_ls = 0, exp_fs = 0;
    int pd_de = 0, pd_x = 0, pd_y = 0, pd_ls = 0, pd_fs = 0;
    bit chk_pix = 0;
    int cyc = 0;
    int ls_cnt = 0, fs_cnt = 0, both_cnt = 0, err_cnt = 0;
    int last_ls_cyc = 0, err_cyc = 0, err_h = 0;
    bit locked_seen = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_span(input int ln, input int from, input int to);
        for (int c = from; c < to; c++) begin
            bit de;
            de = (ln >= Y0) && (ln < Y0 + YA) && (c >= X0) && (c < X0 + XA);
            @(negedge clk);
            vga_HS  = !(c < HS_W);
            vga_VS  = !(ln < VS_L);
            display = de;
            exp_de  = de ? 1 : 0;
            exp_x   = de ? c - X0 : 0;
            exp_y   = de ? ln - Y0 : 0;
            exp_ls  = (c == 0) ? 1 : 0;
            exp_fs  = (c == 0 && ln == 0) ? 1 : 0;
        end
    endtask

    task automatic drive_frame(input int stretch_ln);
        for (int ln = 0; ln < V; ln++)
            drive_span(ln, 0, (ln == stretch_ln) ? H + 1 : H);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_x"}, int'(rx_X), 0);
        chk({tag, "_rx_y"}, int'(rx_Y), 0);
        chk({tag, "_pv"}, int'(pixel_valid), 0);
        chk({tag, "_h_total"}, int'(h_total), 0);
        chk({tag, "_v_total"}, int'(v_total), 0);
        chk({tag, "_ls"}, int'(line_start), 0);
        chk({tag, "_fs"}, int'(frame_start), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_terr"}, int'(timing_error), 0);
    endtask

    // monitor: pulse bookkeeping and, when enabled, cycle-exact checks
    // of outputs against the stimulus driven two edges earlier
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (line_start) begin
            ls_cnt++;
            last_ls_cyc = cyc;
        end
        if (frame_start) fs_cnt++;
        if (line_start && frame_start) both_cnt++;
        if (timing_error) begin
            err_cnt++;
            err_cyc = cyc;
            err_h   = int'(h_total);
        end
        if (locked) locked_seen = 1;
        if (chk_pix) begin
            chk("pix_pv", int'(pixel_valid), pd_de);
            chk("pix_rx_x", int'(rx_X), pd_x);
            chk("pix_rx_y", int'(rx_Y), pd_y);
            chk("pix_ls", int'(line_start), pd_ls);
            chk("pix_fs", int'(frame_start), pd_fs);
        end
        pd_de = exp_de;
        pd_x  = exp_x;
        pd_y  = exp_y;
        pd_ls = exp_ls;
        pd_fs = exp_fs;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got time-limit expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        vga_HS  = 1'b1;
        vga_VS  = 1'b1;
        display = 1'b0;
        repeat (4) @(negedge clk);
        chk_all_zero("rst");

        // release on the first clock of frame 1 with both syncs low:
        // the cleared input stage sees no edge, so frame 2 gives the
        // first frame_start, carrying a full-frame measurement
        @(negedge clk);
        reset = 1'b0;
        vga_HS = 1'b0;
        vga_VS = 1'b0;
        drive_span(0, 1, H);
        for (int ln = 1; ln < V; ln++) drive_span(ln, 0, H);
        chk("f1_locked", int'(locked), 0);
        chk("f1_fs_cnt", fs_cnt, 0);
        drive_frame(-1);
        chk("f2_locked", int'(locked), 0);
        chk("f2_v_total", int'(v_total), V);
        chk_pix = 1;
        drive_frame(-1);
        chk_pix = 0;
        chk("f3_locked", int'(locked), 1);
        chk("f3_h_total", int'(h_total), H);
        chk("f3_v_total", int'(v_total), V);
        chk("f3_fs_cnt", fs_cnt, 2);
        chk("f3_ls_cnt", ls_cnt, 23);
        chk("f3_both_cnt", both_cnt, 2);
        chk("f3_err_cnt", err_cnt, 0);

        // one 801-clock line while locked
        drive_frame(3);
        chk("st_err_cnt", err_cnt, 1);
        chk("st_err_h", err_h, H + 1);
        chk("st_locked", int'(locked), 0);
        drive_frame(-1);
        drive_frame(-1);
        chk("st_relock", int'(locked), 1);
        chk("st_err_cnt2", err_cnt, 1);

        // reset mid-line while locked and showing pixels
        for (int ln = 0; ln < 5; ln++) drive_span(ln, 0, H);
        drive_span(5, 0, 301);
        chk("pre_rst_locked", int'(locked), 1);
        chk("pre_rst_pv", int'(pixel_valid), 1);
        reset = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        drive_span(5, 301, 305);
        reset = 1'b0;
        locked_seen = 0;
        drive_span(5, 305, H);
        drive_span(6, 0, H);
        drive_span(7, 0, H);
        drive_frame(-1);
        chk("post_rst_locked", int'(locked), 0);
        chk("post_rst_seen", int'(locked_seen), 0);
        chk("post_rst_err", err_cnt, 1);
        drive_frame(-1);

        // hold HS high while locked until the line counter saturates
        for (int ln = 0; ln < 3; ln++) drive_span(ln, 0, H);
        chk("hold_pre_locked", int'(locked), 1);
        chk("hold_pre_err", err_cnt, 1);
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            vga_HS  = 1'b1;
            vga_VS  = 1'b1;
            display = 1'b0;
        end
        chk("hold_err_cnt", err_cnt, 2);
        chk("hold_err_delay", err_cyc - last_ls_cyc, 1024);
        chk("hold_locked", int'(locked), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
